// File: rtl/surf_scaler_bank_pkg.sv
// Shared types and constants for the SURF trigger scaler bank.
// Optional feature macro: SCALER_OVF_EN (per-channel saturation flags).
package surf_scaler_bank_pkg;

  localparam int unsigned CNT_W_DEF = 16;
  localparam int unsigned ADDR_W    = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  // Address whose read strobe acknowledges a complete snapshot readout.
  function automatic logic [ADDR_W-1:0] last_addr(input int unsigned num_ch);
    return ADDR_W'(num_ch - 1);
  endfunction

endpackage

// File: rtl/surf_scaler_bank_if.sv
// Readout bus between the scaler bank and the local-bus HK space 0 logic.
// Optional feature macro: SCALER_OVF_EN (not used by this interface).
interface surf_scaler_bank_if #(
  parameter int unsigned CNT_W = surf_scaler_bank_pkg::CNT_W_DEF
);

  logic [surf_scaler_bank_pkg::ADDR_W-1:0] scal_addr_i;
  logic                                    scal_rd_i;
  logic [CNT_W-1:0]                        scal_dat_o;
  logic [CNT_W-1:0]                        refpulse_cnt_o;
  logic                                    scal_new_o;

  modport slave (
    input  scal_addr_i,
    input  scal_rd_i,
    output scal_dat_o,
    output refpulse_cnt_o,
    output scal_new_o
  );

  modport master (
    output scal_addr_i,
    output scal_rd_i,
    input  scal_dat_o,
    input  refpulse_cnt_o,
    input  scal_new_o
  );

endinterface

// File: rtl/surf_scaler_bank_counter.sv
// One scaler channel: rising-edge detect and saturating live counter.
// Optional feature macro: SCALER_OVF_EN adds a sticky saturation flag.
module surf_scaler_counter
  import surf_scaler_bank_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             terminal,
  input  logic             in,
  output logic [CNT_W-1:0] snap_cnt
`ifdef SCALER_OVF_EN
  ,
  output logic             snap_ovf
`endif
);

  logic             in_q;
  logic             hit;
  logic             at_max;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  always_ff @(posedge clk) begin
    if (rst) in_q <= 1'b0;
    else     in_q <= in;
  end

  assign hit      = in & ~in_q;
  assign at_max   = &cnt;
  assign cnt_next = (hit && !at_max) ? cnt + CNT_W'(1) : cnt;

  // Snapshot value includes the terminal-cycle hit, so it belongs to the closing period.
  assign snap_cnt = cnt_next;

  always_ff @(posedge clk) begin
    if (rst || !run)   cnt <= '0;
    else if (terminal) cnt <= '0;
    else               cnt <= cnt_next;
  end

`ifdef SCALER_OVF_EN
  logic ovf;
  logic ovf_next;

  assign ovf_next = ovf | (hit & at_max);
  assign snap_ovf = ovf_next;

  always_ff @(posedge clk) begin
    if (rst || !run)   ovf <= 1'b0;
    else if (terminal) ovf <= 1'b0;
    else               ovf <= ovf_next;
  end
`endif

endmodule

// File: rtl/surf_scaler_bank.sv
// SURF housekeeping trigger scalers: gated counting, periodic snapshot, readout mux.
// Optional feature macro: SCALER_OVF_EN (per-channel saturation flags on scal_ovf_o).
module surf_scaler_bank
  import surf_scaler_bank_pkg::*;
#(
  parameter int unsigned NUM_CH      = 32,
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned PERIOD_CLKS = 33000000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic [NUM_CH-1:0]    trig_i,
  input  logic                 refpulse_i,
  surf_scaler_bank_if.slave    bus,
  output logic                 period_stb_o,
  output logic [NUM_CH-1:0]    scal_ovf_o
);

  localparam int unsigned PW = $clog2(PERIOD_CLKS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = last_addr(NUM_CH);

  state_t           state_q;
  state_t           state_d;
  logic             run;
  logic             terminal;
  logic [PW-1:0]    period_cnt;
  logic [NUM_CH:0]  in_all;
  logic [CNT_W-1:0] snap_cnt [NUM_CH+1];
  logic [CNT_W-1:0] snap     [NUM_CH+1];
  logic [CNT_W-1:0] rd_mux;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable_i)  state_d = COUNT;
      COUNT:   if (!enable_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign run      = (state_q == COUNT);
  assign terminal = run && (period_cnt == PW'(PERIOD_CLKS - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i || !run) period_cnt <= '0;
    else if (terminal) period_cnt <= '0;
    else               period_cnt <= period_cnt + PW'(1);
  end

  // Top slot counts the reference pulse; it shares the trigger channel logic.
  assign in_all = {refpulse_i, trig_i};

`ifdef SCALER_OVF_EN
  logic [NUM_CH:0] snap_ovf;
`endif

  for (genvar g = 0; g <= NUM_CH; g++) begin : g_ch
    surf_scaler_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk      (clk_i),
      .rst      (rst_i),
      .run      (run),
      .terminal (terminal),
      .in       (in_all[g]),
      .snap_cnt (snap_cnt[g])
`ifdef SCALER_OVF_EN
      ,
      .snap_ovf (snap_ovf[g])
`endif
    );
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i <= NUM_CH; i++) snap[i] <= '0;
    end else if (terminal) begin
      for (int unsigned i = 0; i <= NUM_CH; i++) snap[i] <= snap_cnt[i];
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (bus.scal_addr_i == ADDR_W'(i)) rd_mux = snap[i];
    end
  end

  assign bus.refpulse_cnt_o = snap[NUM_CH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus.scal_dat_o <= '0;
      bus.scal_new_o <= 1'b0;
      period_stb_o   <= 1'b0;
    end else begin
      bus.scal_dat_o <= rd_mux;
      period_stb_o   <= terminal;
      // A new snapshot outranks an acknowledge on the same edge.
      if (terminal)
        bus.scal_new_o <= 1'b1;
      else if (bus.scal_rd_i && (bus.scal_addr_i == LAST_ADDR))
        bus.scal_new_o <= 1'b0;
    end
  end

`ifdef SCALER_OVF_EN
  always_ff @(posedge clk_i) begin
    if (rst_i)         scal_ovf_o <= '0;
    else if (terminal) scal_ovf_o <= snap_ovf[NUM_CH-1:0];
  end
`else
  assign scal_ovf_o = '0;
`endif

endmodule
